// File: rtl/sid_voice_sched.sv
// rtl/sid_voice_sched.sv - time-multiplexed phase accumulator / noise LFSR scheduler for three SID voices
module sid_voice_sched #(
  parameter int NVOICE    = 3,
  parameter int ACC_W     = 24,
  parameter int LFSR_W    = 23,
  parameter int NOISE_BIT = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              wr_en,
  input  logic [1:0]        wr_voice,
  input  logic [1:0]        wr_sel,
  input  logic [7:0]        wr_data,
  output logic              busy,
  output logic              out_valid,
  output logic [1:0]        out_voice,
  output logic [ACC_W-1:0]  out_acc,
  output logic [LFSR_W-1:0] out_lfsr,
  output logic              out_msb_rise,
  output logic              tick_lost
);

  localparam logic [1:0] LAST_SLOT = 2'(NVOICE - 1);
  localparam int         LFSR_TAP  = 17;

  typedef enum logic {IDLE, SLOT} state_t;

  state_t            state, state_nxt;
  logic [1:0]        slot;
  logic [1:0]        prev_slot;

  logic [15:0]       freq [NVOICE];
  logic [NVOICE-1:0] sync_en;
  logic [NVOICE-1:0] test_en;
  logic [ACC_W-1:0]  acc  [NVOICE];
  logic [LFSR_W-1:0] lfsr [NVOICE];
  logic [NVOICE-1:0] rise_cur;
  logic [NVOICE-1:0] rise_prev;

  logic [ACC_W-1:0]  acc_cur, acc_nxt;
  logic [LFSR_W-1:0] lfsr_cur, lfsr_nxt;
  logic              rise_nxt;
  logic              wr_ok;

  assign busy      = (state == SLOT);
  assign prev_slot = (slot == 2'd0) ? LAST_SLOT : slot - 2'd1;
  assign wr_ok     = wr_en && (int'(wr_voice) < NVOICE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: one tick launches NVOICE consecutive slots
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = SLOT;
      SLOT:    if (slot == LAST_SLOT) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slot counter restarts at voice 0 every sequence
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  slot <= 2'd0;
    else if (state == IDLE || slot == LAST_SLOT) slot <= 2'd0;
    else                                        slot <= slot + 2'd1;
  end

  // Freeze last tick's MSB rise flags so sync is independent of voice order
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      rise_prev <= '0;
    else if (state == IDLE && tick) rise_prev <= rise_cur;
  end

  // Shared update datapath for the voice in the current slot; test beats sync beats add
  always_comb begin
    acc_cur  = acc[slot];
    lfsr_cur = lfsr[slot];
    acc_nxt  = acc_cur + {{(ACC_W-16){1'b0}}, freq[slot]};
    lfsr_nxt = lfsr_cur;
    if (test_en[slot]) begin
      acc_nxt  = '0;
      lfsr_nxt = '1;
    end else begin
      if (sync_en[slot] && rise_prev[prev_slot]) acc_nxt = '0;
      if (!acc_cur[NOISE_BIT] && acc_nxt[NOISE_BIT])
        lfsr_nxt = {lfsr_cur[LFSR_W-2:0], lfsr_cur[LFSR_W-1] ^ lfsr_cur[LFSR_TAP]};
    end
    rise_nxt = !acc_cur[ACC_W-1] && acc_nxt[ACC_W-1];
  end

  // Per-voice running state, committed at the end of that voice's slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NVOICE; v++) begin
        acc[v]  <= '0;
        lfsr[v] <= '1;
      end
      rise_cur <= '0;
    end else if (state == SLOT) begin
      acc[slot]      <= acc_nxt;
      lfsr[slot]     <= lfsr_nxt;
      rise_cur[slot] <= rise_nxt;
    end
  end

  // CPU register writes; a write lands after any same-cycle slot read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NVOICE; v++) freq[v] <= '0;
      sync_en <= '0;
      test_en <= '0;
    end else if (wr_ok) begin
      case (wr_sel)
        2'd0: freq[wr_voice][7:0]  <= wr_data;
        2'd1: freq[wr_voice][15:8] <= wr_data;
        2'd2: begin
          sync_en[wr_voice] <= wr_data[1];
          test_en[wr_voice] <= wr_data[3];
        end
        default: ;
      endcase
    end
  end

  // Result stream to the waveform stage and lost-tick flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_voice    <= '0;
      out_acc      <= '0;
      out_lfsr     <= '0;
      out_msb_rise <= 1'b0;
      tick_lost    <= 1'b0;
    end else begin
      out_valid <= (state == SLOT);
      tick_lost <= (state == SLOT) && tick;
      if (state == SLOT) begin
        out_voice    <= slot;
        out_acc      <= acc_nxt;
        out_lfsr     <= lfsr_nxt;
        out_msb_rise <= rise_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sid_voice_sched.sv
// tb/tb_sid_voice_sched.sv - scoreboard bench for sid_voice_sched
module tb_sid_voice_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_voice = '0;
  logic [1:0]  wr_sel = '0;
  logic [7:0]  wr_data = '0;
  logic        busy, out_valid, out_msb_rise, tick_lost;
  logic [1:0]  out_voice;
  logic [23:0] out_acc;
  logic [22:0] out_lfsr;

  sid_voice_sched dut (
    .clk(clk), .reset(reset), .tick(tick), .wr_en(wr_en), .wr_voice(wr_voice),
    .wr_sel(wr_sel), .wr_data(wr_data), .busy(busy), .out_valid(out_valid),
    .out_voice(out_voice), .out_acc(out_acc), .out_lfsr(out_lfsr),
    .out_msb_rise(out_msb_rise), .tick_lost(tick_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  voice;
    logic [23:0] acc;
    logic [22:0] lfsr;
    logic        rise;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int valid_count = 0;

  logic [23:0] last_acc  [4];
  logic [22:0] last_lfsr [4];
  logic        last_rise [4];

  // reference state
  logic [23:0] m_acc  [3];
  logic [22:0] m_lfsr [3];
  logic [15:0] m_freq [3];
  logic [2:0]  m_sync, m_test, m_rise;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 3; v++) begin
      m_acc[v] = '0; m_lfsr[v] = '1; m_freq[v] = '0;
    end
    m_sync = '0; m_test = '0; m_rise = '0;
  endtask

  task automatic model_tick(input int npush);
    logic [2:0]  prev;
    logic [23:0] a, an;
    logic [22:0] l;
    exp_t e;
    prev = m_rise;
    for (int v = 0; v < 3; v++) begin
      a  = m_acc[v];
      an = a + {8'd0, m_freq[v]};
      l  = m_lfsr[v];
      if (m_sync[v] && prev[(v + 2) % 3]) an = '0;
      if (m_test[v]) begin
        an = '0; l = '1;
      end else if (!a[19] && an[19]) begin
        l = {l[21:0], l[22] ^ l[17]};
      end
      m_rise[v] = !a[23] && an[23];
      m_acc[v]  = an;
      m_lfsr[v] = l;
      if (v < npush) begin
        e.voice = 2'(v); e.acc = an; e.lfsr = l; e.rise = m_rise[v];
        sb.push_back(e);
      end
    end
  endtask

  task automatic wr(input logic [1:0] v, input logic [1:0] s, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_voice = v; wr_sel = s; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (v < 2'd3) begin
      case (s)
        2'd0: m_freq[v][7:0]  = d;
        2'd1: m_freq[v][15:8] = d;
        2'd2: begin m_sync[v] = d[1]; m_test[v] = d[3]; end
        default: ;
      endcase
    end
  endtask

  task automatic set_freq(input logic [1:0] v, input logic [15:0] f);
    wr(v, 2'd0, f[7:0]);
    wr(v, 2'd1, f[15:8]);
  endtask

  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    model_tick(3);
    @(negedge clk);
    tick = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  // monitor: every presented result is popped and compared
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid) begin
      valid_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got voice %0d acc 0x%0h, expected no output", out_voice, out_acc);
      end else begin
        e = sb.pop_front();
        check("sb_voice", 32'(out_voice), 32'(e.voice));
        check("sb_acc", 32'(out_acc), 32'(e.acc));
        check("sb_lfsr", 32'(out_lfsr), 32'(e.lfsr));
        check("sb_rise", 32'(out_msb_rise), 32'(e.rise));
      end
      last_acc[out_voice]  = out_acc;
      last_lfsr[out_voice] = out_lfsr;
      last_rise[out_voice] = out_msb_rise;
    end
  end

  initial begin
    logic exp_busy [5];
    logic exp_vld  [5];
    int   vc0;
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_vld  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int v = 0; v < 4; v++) begin
      last_acc[v] = 'x; last_lfsr[v] = 'x; last_rise[v] = 1'bx;
    end
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_acc", 32'(out_acc), 0);
    check("rst_lfsr", 32'(out_lfsr), 0);
    check("rst_lost", 32'(tick_lost), 0);
    reset = 1'b0;

    // basic stepping and slot timing
    set_freq(2'd0, 16'h1000);
    @(negedge clk);
    tick = 1'b1;
    model_tick(3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tick = 1'b0;
      check("lat_busy", 32'(busy), 32'(exp_busy[i]));
      check("lat_valid", 32'(out_valid), 32'(exp_vld[i]));
    end
    repeat (2) @(negedge clk);
    ticks(4);
    check("step_acc0", 32'(last_acc[0]), 32'h005000);
    check("step_acc1", 32'(last_acc[1]), 0);
    check("step_acc2", 32'(last_acc[2]), 0);
    check("step_lfsr0", 32'(last_lfsr[0]), 32'h7FFFFF);

    // noise clocking, MSB rise and wrap
    set_freq(2'd0, 16'hFFFF);
    ticks(8);
    check("lfsr_rise_acc", 32'(last_acc[0]), 32'h084FF8);
    check("lfsr_shift", 32'(last_lfsr[0]), 32'h7FFFFE);
    ticks(8);
    check("lfsr_fall_acc", 32'(last_acc[0]), 32'h104FF0);
    check("lfsr_noshift", 32'(last_lfsr[0]), 32'h7FFFFE);
    ticks(112);
    check("msb_acc", 32'(last_acc[0]), 32'h804F80);
    check("msb_rise", 32'(last_rise[0]), 1);
    ticks(128);
    check("wrap_acc", 32'(last_acc[0]), 32'h004F00);
    check("wrap_rise", 32'(last_rise[0]), 0);

    // hard sync from voice 2 into voice 0, one tick later
    set_freq(2'd0, 16'h0100);
    wr(2'd0, 2'd2, 8'h02);
    set_freq(2'd2, 16'hFFFF);
    ticks(129);
    check("sync_src_rise", 32'(last_rise[2]), 1);
    check("sync_src_acc", 32'(last_acc[2]), 32'h80FF7F);
    check("sync_same_tick", 32'(last_acc[0]), 32'h00D000);
    ticks(1);
    check("sync_next_tick", 32'(last_acc[0]), 0);
    ticks(1);
    check("sync_resume", 32'(last_acc[0]), 32'h000100);
    wr(2'd0, 2'd2, 8'h00);

    // ignored writes
    wr(2'd3, 2'd0, 8'hFF);
    wr(2'd0, 2'd3, 8'hFF);
    ticks(1);
    check("ignored_wr", 32'(last_acc[0]), 32'h000200);

    // test bit holds voice at zero / all ones
    set_freq(2'd1, 16'h1234);
    ticks(2);
    check("pretest_acc1", 32'(last_acc[1]), 32'h002468);
    wr(2'd1, 2'd2, 8'h08);
    for (int i = 0; i < 3; i++) begin
      ticks(1);
      check("test_acc1", 32'(last_acc[1]), 0);
      check("test_lfsr1", 32'(last_lfsr[1]), 32'h7FFFFF);
    end
    wr(2'd1, 2'd2, 8'h00);
    ticks(1);
    check("posttest_acc1", 32'(last_acc[1]), 32'h001234);

    // ticks arriving mid-sequence are dropped
    for (int gap = 2; gap <= 3; gap++) begin
      @(negedge clk);
      tick = 1'b1;
      model_tick(3);
      vc0 = valid_count;
      for (int i = 1; i <= 6; i++) begin
        @(negedge clk);
        check("tick_lost", 32'(tick_lost), 32'(i == gap + 1));
        tick = (i == gap);
      end
      check("lost_valid_cnt", 32'(valid_count - vc0), 3);
    end

    // reset in the middle of a sequence
    @(negedge clk);
    tick = 1'b1;
    model_tick(1);
    model_reset();
    @(negedge clk);
    tick = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    ticks(1);
    check("postrst_acc0", 32'(last_acc[0]), 0);
    check("postrst_lfsr0", 32'(last_lfsr[0]), 32'h7FFFFF);

    check("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
